pdm_mic_frontend: RTL and testbench

Parametrised PDM microphone front-end. It generates the mic clock, decimates the 1-bit PDM stream into signed PCM samples, and buffers them in a small FIFO. Samples leave on a valid/ready stream with a frame-boundary last flag, ready for the FFT input. It replaces the hand-built mic-clock, tally and frame-count logic in top_level with one reusable block.

---
 rtl/pdm_mic_frontend.sv | 140 ++++++++++++++
 tb/tb_pdm_mic_frontend.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_frontend.sv
// pdm_mic_frontend: mic clock generation, PDM-to-PCM decimation and output FIFO with frame flag.
// Optional first-order DC removal stage when PDM_DC_BLOCK_EN is defined.
module pdm_mic_frontend #(
   parameter int CLK_DIV    = 32,
   parameter int DECIM      = 256,
   parameter int SAMPLE_W   = 8,
   parameter int FRAME_LEN  = 1024,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         en_in,
   input  logic                         mic_data,
   output logic                         mic_clk,
   output logic [SAMPLE_W-1:0]          out_tdata,
   output logic                         out_tvalid,
   output logic                         out_tlast,
   input  logic                         out_tready,
   output logic                         overflow_out,
   output logic [$clog2(FRAME_LEN)-1:0] frame_cnt_out
);
   localparam int HALF = CLK_DIV / 2;
   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DECIM);
   localparam int TW = BW + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FRAME_LEN);
   localparam int SMAX = (1 << (SAMPLE_W - 1)) - 1;
   localparam int SMIN = -(1 << (SAMPLE_W - 1));

   function automatic logic [SAMPLE_W-1:0] sat(input int v);
      return v > SMAX ? SAMPLE_W'(SMAX) : v < SMIN ? SAMPLE_W'(SMIN) : SAMPLE_W'(v);
   endfunction

   logic [CW-1:0] cnt, cnt_nx;
   logic s1, s2, stb, last_bit;
   logic [BW-1:0] bits;
   logic [TW-1:0] tally;
   logic [SAMPLE_W-1:0] s_data, w_data;
   logic s_vld, w_vld;
   int raw;

   always_comb begin
      cnt_nx = !en_in ? '0 : (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
      stb = en_in && cnt == CW'(HALF - 1);
      last_bit = stb && bits == BW'(DECIM - 1);
      raw = int'(tally) + int'(s2) - DECIM / 2;
   end

   // the final bit is folded in combinationally so the tally can restart with no gap bit
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt <= '0;
         mic_clk <= 1'b0;
         s1 <= 1'b0;
         s2 <= 1'b0;
         bits <= '0;
         tally <= '0;
         s_vld <= 1'b0;
         s_data <= '0;
      end else begin
         cnt <= cnt_nx;
         mic_clk <= en_in && cnt_nx < CW'(HALF);
         s1 <= mic_data;
         s2 <= s1;
         s_vld <= last_bit;
         if (last_bit) s_data <= sat(raw);
         if (!en_in) begin
            bits <= '0;
            tally <= '0;
         end else if (stb) begin
            bits <= bits + 1'b1;
            tally <= last_bit ? '0 : tally + TW'(s2);
         end
      end
   end

`ifdef PDM_DC_BLOCK_EN
   logic signed [SAMPLE_W+3:0] acc;
   int d;
   always_comb d = int'($signed(s_data)) - int'(acc >>> 4);
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         acc <= '0;
         w_vld <= 1'b0;
         w_data <= '0;
      end else begin
         w_vld <= s_vld;
         if (s_vld) begin
            acc <= acc + (SAMPLE_W + 4)'(d);
            w_data <= sat(d);
         end
      end
   end
`else
   always_comb begin
      w_data = s_data;
      w_vld = s_vld;
   end
`endif

   logic [SAMPLE_W-1:0] mem_d [FIFO_DEPTH];
   logic mem_l [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] fill;
   logic rd, wr, frame_end;

   always_comb begin
      out_tvalid = fill != '0;
      out_tdata = out_tvalid ? mem_d[rp] : '0;
      out_tlast = out_tvalid && mem_l[rp];
      rd = out_tvalid && out_tready;
      wr = w_vld && (fill != (AW + 1)'(FIFO_DEPTH) || rd);
      frame_end = frame_cnt_out == FW'(FRAME_LEN - 1);
   end

   always_ff @(posedge clk_in) begin
      if (wr) begin
         mem_d[wp] <= w_data;
         mem_l[wp] <= frame_end;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wp <= '0;
         rp <= '0;
         fill <= '0;
         overflow_out <= 1'b0;
         frame_cnt_out <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         fill <= fill + (AW + 1)'(wr) - (AW + 1)'(rd);
         if (w_vld && !wr) overflow_out <= 1'b1;
         if (!en_in) frame_cnt_out <= '0;
         else if (wr) frame_cnt_out <= frame_end ? '0 : frame_cnt_out + 1'b1;
      end
   end
endmodule

// File: tb/tb_pdm_mic_frontend.sv
// tb_pdm_mic_frontend: directed checks of decimation, latency, FIFO overflow, framing, enable and reset.
module tb_pdm_mic_frontend;
   localparam int CLK_DIV = 4, DECIM = 256, SAMPLE_W = 8, FRAME_LEN = 8, FIFO_DEPTH = 4;

   logic clk_in = 0, rst_in = 1, en_in = 1, mic_data = 0, out_tready = 1;
   logic mic_clk, out_tvalid, out_tlast, overflow_out;
   logic [SAMPLE_W-1:0] out_tdata;
   logic [$clog2(FRAME_LEN)-1:0] frame_cnt_out;

   pdm_mic_frontend #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .SAMPLE_W(SAMPLE_W),
                      .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .mic_data(mic_data),
      .mic_clk(mic_clk), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
      .out_tlast(out_tlast), .out_tready(out_tready), .overflow_out(overflow_out),
      .frame_cnt_out(frame_cnt_out));

   always #5 clk_in = ~clk_in;

   int nchk = 0, nerr = 0, cyc = 0, bidx = 0, mode = 1, t0;
   logic prev = 0;
   // ramp mode: sample k holds 100+20k ones -> -28, -8, 12, 32, 52
   logic [7:0] ramp_exp [5] = '{8'hE4, 8'hF8, 8'h0C, 8'h20, 8'h34};

   // bit b of the stream; ramp puts its ones at the end of each window so bit 0 is always 0
   function automatic logic pat(input int b);
      int k;
      k = (b / 256) % 8;
      return mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? b[0] : (b % 256) >= 256 - (100 + 20 * k);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock; the next PDM bit is presented right after each mic_clk fall
   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      if (prev && !mic_clk) begin
         bidx++;
         mic_data = pat(bidx);
      end
      prev = mic_clk;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic restart(input int m);
      rst_in = 1;
      mode = m;
      ticks(2);
      rst_in = 0;
      bidx = 0;
      prev = 0;
      mic_data = pat(0);
   endtask

   task automatic wait_bits(input int n);
      int k = 0;
      while (bidx < n && k < 20000) begin
         tick();
         k++;
      end
      if (bidx < n) chk("timeout_bits", bidx, n);
   endtask

   task automatic pop(input string tag, input logic [7:0] d, input logic l);
      int k = 0;
      while (!out_tvalid && k < 3000) begin
         tick();
         k++;
      end
      chk({tag, "_valid"}, out_tvalid, 1);
      chk({tag, "_data"}, out_tdata, d);
      chk({tag, "_last"}, out_tlast, l);
      if (out_tready) tick();
   endtask

   initial begin
      ticks(2);
      chk("rst_tvalid", out_tvalid, 0);
      chk("rst_tdata", out_tdata, 0);
      chk("rst_tlast", out_tlast, 0);
      chk("rst_ovf", overflow_out, 0);
      chk("rst_frame", frame_cnt_out, 0);
      chk("rst_mic_clk", mic_clk, 0);
      restart(1);
      wait_bits(256);
      chk("lat_early", out_tvalid, 0);
      tick();
      chk("lat_valid", out_tvalid, 1);
      chk("lat_data", out_tdata, 8'h7F);
      t0 = cyc;
      tick();
      for (int k = 0; k < 3000 && !out_tvalid; k++) tick();
      chk("period", cyc - t0, CLK_DIV * DECIM);
      chk("ones_data", out_tdata, 8'h7F);
      tick();

      restart(0);
      pop("zeros", 8'h80, 0);
      restart(2);
      pop("alt0", 8'h00, 0);
      pop("alt1", 8'h00, 0);

      restart(3);
      out_tready = 0;
      wait_bits(4 * 256);
      ticks(3);
      chk("full_ovf", overflow_out, 0);
      chk("full_valid", out_tvalid, 1);
      chk("full_head", out_tdata, ramp_exp[0]);
      chk("full_frame", frame_cnt_out, 4);
      wait_bits(5 * 256);
      ticks(3);
      chk("drop_ovf", overflow_out, 1);
      chk("drop_hold", out_tdata, ramp_exp[0]);
      chk("drop_frame", frame_cnt_out, 4);
      out_tready = 1;
      for (int i = 0; i < 4; i++) pop("drain", ramp_exp[i], 0);
      chk("drain_empty", out_tvalid, 0);
      chk("ovf_sticky", overflow_out, 1);

      restart(1);
      for (int i = 0; i < 16; i++) begin
         pop("frame", 8'h7F, i == 7 || i == 15);
         chk("frame_cnt", frame_cnt_out, (i + 1) % 8);
      end

      restart(3);
      pop("en_first", ramp_exp[0], 0);
      wait_bits(256 + 100);
      en_in = 0;
      ticks(3);
      chk("en_frame_clr", frame_cnt_out, 0);
      chk("en_mic_clk", mic_clk, 0);
      bidx = 0;
      prev = 0;
      mic_data = pat(0);
      ticks(3);
      chk("en_no_write", out_tvalid, 0);
      en_in = 1;
      pop("en_fresh", ramp_exp[0], 0);
      chk("en_frame", frame_cnt_out, 1);

      restart(3);
      out_tready = 0;
      wait_bits(512);
      ticks(3);
      chk("rm_valid", out_tvalid, 1);
      chk("rm_frame", frame_cnt_out, 2);
      rst_in = 1;
      tick();
      chk("rm_tvalid", out_tvalid, 0);
      chk("rm_tdata", out_tdata, 0);
      chk("rm_tlast", out_tlast, 0);
      chk("rm_frame0", frame_cnt_out, 0);
      chk("rm_mic_clk", mic_clk, 0);
      rst_in = 0;
      bidx = 0;
      prev = 0;
      mic_data = pat(0);
      out_tready = 1;
      pop("rm_first", ramp_exp[0], 0);
      chk("rm_frame1", frame_cnt_out, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
